// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the signed sequential shift-add multiplier.
// Imported by the datapath and by the control unit.
package seq_mult_pkg;

    localparam int DW    = 8;
    localparam int CNT_W = $clog2(DW + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE,
        ST_HOLD
    } seq_state_t;

endpackage

// File: rtl/seq_mult_ctrl_down_counter.sv
// Loadable down-counter with a synchronous clear and a "count is one" flag.
// The decrement saturates at zero so the count can never wrap.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         is_one
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign count  = count_reg;
    assign is_one = (count_reg == W'(1));

endmodule

// File: rtl/seq_mult_ctrl.sv
// Moore control FSM for the signed sequential multiplier: load, DW shifts, one ready pulse.
// Optional abort input is enabled with the SEQ_MULT_ABORT_EN macro.
module seq_mult_ctrl #(
    parameter int DW = seq_mult_pkg::DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
`ifdef SEQ_MULT_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     load_ctrl_sgnl,
    output logic                     shift_ctrl_sgnl,
    output logic                     clear_ctrl_sgnl,
    output logic                     ready_ctrl_sgnl,
    output logic                     busy,
    output logic [$clog2(DW+1)-1:0]  bit_cnt
);

    import seq_mult_pkg::*;

    localparam int CW = $clog2(DW + 1);

    seq_state_t    state_reg;
    seq_state_t    state_next;
    logic          abort_hit;
    logic          cnt_clr;
    logic          cnt_is_one;
    logic [CW-1:0] cnt_value;

`ifdef SEQ_MULT_ABORT_EN
    // An abort in IDLE is meaningless and must not disturb anything.
    assign abort_hit = abort && (state_reg != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign cnt_clr = !rst || abort_hit;

    down_counter #(
        .W (CW)
    ) u_bit_counter (
        .clk      (clk),
        .clr      (cnt_clr),
        .load     (state_reg == ST_LOAD),
        .dec      (state_reg == ST_SHIFT),
        .load_val (CW'(DW)),
        .count    (cnt_value),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SYNC;
            ST_SYNC:  state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            // The count still reads 1 during the last shift cycle.
            ST_SHIFT: if (cnt_is_one) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (!start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        load_ctrl_sgnl  = 1'b0;
        shift_ctrl_sgnl = 1'b0;
        clear_ctrl_sgnl = 1'b0;
        ready_ctrl_sgnl = 1'b0;
        busy            = 1'b0;
        case (state_reg)
            ST_IDLE:  clear_ctrl_sgnl = 1'b1;
            ST_SYNC:  busy = 1'b1;
            ST_LOAD: begin
                load_ctrl_sgnl  = 1'b1;
                clear_ctrl_sgnl = 1'b1;
                busy            = 1'b1;
            end
            ST_SHIFT: begin
                shift_ctrl_sgnl = 1'b1;
                busy            = 1'b1;
            end
            ST_DONE: begin
                ready_ctrl_sgnl = 1'b1;
                busy            = 1'b1;
            end
            default: ;
        endcase
    end

    assign bit_cnt = cnt_value;

endmodule
